// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signals of the set-associative instruction cache.
// slave is the cache's view; master is the datapath plus memory view.
interface icache_sa_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with true-LRU replacement, combinational hits
// and a block fill state machine on misses.
module icache_sa #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input logic        CLK,
  input logic        nRST,
  icache_sa_if.slave bus
);

  localparam int unsigned OFF  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - OFF - IDX;
  localparam int unsigned OFFW = (OFF > 0) ? OFF : 1;
  localparam int unsigned WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [OFFW-1:0]   cnt_q, cnt_d;
  logic [TAGW-1:0]   base_tag_q, base_tag_d;
  logic [IDX-1:0]    base_idx_q, base_idx_d;
  logic [WAYW-1:0]   victim_q, victim_d;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [WAYW-1:0]   age_q   [WAYS][SETS];
  logic [TAGW-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][BLOCK_WORDS];

  logic [IDX-1:0]    req_idx;
  logic [OFFW-1:0]   req_off;
  logic [TAGW-1:0]   req_tag;
  logic              hit_any, hit;
  logic [WAYW-1:0]   hit_way, victim, max_age;
  logic              found_invalid;
  logic              fill_done;
  logic              lru_en;
  logic [IDX-1:0]    lru_idx;
  logic [WAYW-1:0]   lru_way;
  int unsigned       lru_old;
  logic [31:0]       fill_addr;
  logic              unused_byte_bits;

  assign unused_byte_bits = ^bus.imemaddr[1:0];

  always_comb begin
    req_off = '0;
    if (OFF > 0) req_off = bus.imemaddr[2 +: OFFW];
  end
  assign req_idx = bus.imemaddr[2+OFF +: IDX];
  assign req_tag = bus.imemaddr[31 -: TAGW];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAYW'(w);
      end
    end
  end

  assign hit = bus.imemREN && (state_q == StIdle) && !bus.iflush && hit_any;

  // Victim: lowest-numbered invalid way, else the oldest (lowest index on ties).
  always_comb begin
    victim        = '0;
    max_age       = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_q[w][req_idx]) begin
        victim        = WAYW'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] > max_age) begin
          max_age = age_q[w][req_idx];
          victim  = WAYW'(w);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_tag_d = base_tag_q;
    base_idx_d = base_idx_q;
    victim_d   = victim_q;
    fill_done  = 1'b0;
    if (bus.iflush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.imemREN && !hit_any) begin
            state_d    = StFill;
            base_tag_d = req_tag;
            base_idx_d = req_idx;
            victim_d   = victim;
          end
        end
        StFill: begin
          if (!bus.iwait) begin
            if (cnt_q == OFFW'(BLOCK_WORDS - 1)) begin
              fill_done = 1'b1;
              cnt_d     = '0;
              state_d   = StIdle;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A freshly filled invalid way counts as older than every other way, so all others age.
  always_comb begin
    lru_en  = hit || fill_done;
    lru_idx = hit ? req_idx : base_idx_q;
    lru_way = hit ? hit_way : victim_q;
    if (hit) begin
      lru_old = 32'(age_q[hit_way][req_idx]);
    end else if (valid_q[victim_q][base_idx_q]) begin
      lru_old = 32'(age_q[victim_q][base_idx_q]);
    end else begin
      lru_old = WAYS;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      base_tag_q <= '0;
      base_idx_q <= '0;
      victim_q   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) age_q[w][s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_tag_q <= base_tag_d;
      base_idx_q <= base_idx_d;
      victim_q   <= victim_d;
      if (bus.iflush) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w] <= '0;
          for (int s = 0; s < SETS; s++) age_q[w][s] <= '0;
        end
      end else if (lru_en) begin
        if (fill_done) valid_q[victim_q][base_idx_q] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (WAYW'(w) == lru_way) begin
            age_q[w][lru_idx] <= '0;
          end else if (32'(age_q[w][lru_idx]) < lru_old) begin
            age_q[w][lru_idx] <= age_q[w][lru_idx] + 1'b1;
          end
        end
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge CLK) begin
    if (state_q == StFill && !bus.iwait) begin
      data_q[victim_q][base_idx_q][cnt_q] <= bus.iload;
    end
    if (fill_done) begin
      tag_q[victim_q][base_idx_q] <= base_tag_q;
    end
  end

  assign fill_addr = {base_tag_q, base_idx_q, {(OFF + 2){1'b0}}} + (32'(cnt_q) << 2);

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[hit_way][req_idx][req_off] : 32'h0;
  assign bus.iREN     = (state_q == StFill);
  assign bus.iaddr    = (state_q == StFill) ? fill_addr : 32'h0;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: 8 sets, 2 ways, 2-word blocks, memory returns its
// own address after two wait cycles per word.
module tb_icache_sa;

  localparam int unsigned L = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int unsigned wcnt = 0;

  icache_sa_if ifc ();

  icache_sa #(
    .SETS       (8),
    .WAYS       (2),
    .BLOCK_WORDS(2)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (ifc)
  );

  always #5 CLK = ~CLK;

  // Memory model: each word takes L wait cycles, then is presented with iwait=0.
  assign ifc.iwait = (wcnt != L);
  assign ifc.iload = ifc.iaddr;
  always @(posedge CLK) begin
    if (!ifc.iREN || wcnt == L) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        hit;
    logic        ren;
    logic [31:0] iaddr;
    logic [31:0] load;
  } cyc_t;

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic [31:0] data;
  } fetch_t;

  cyc_t   cyc_tab[8];
  fetch_t fetch_tab[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Present a fetch and hold it until ihit; a miss must take exactly 7 ihit=0 cycles.
  task automatic fetch(input logic [31:0] addr, input logic exp_miss, input logic [31:0] exp_data);
    int zeros;
    @(negedge CLK);
    ifc.imemREN  = 1'b1;
    ifc.imemaddr = addr;
    #1;
    zeros = 0;
    while (!ifc.ihit && zeros < 100) begin
      zeros++;
      @(negedge CLK);
      #1;
    end
    chk("fetch_missed", 32'(zeros != 0), 32'(exp_miss));
    if (exp_miss) chk("miss_zero_cycles", 32'(zeros), 32'd7);
    chk("fetch_data", ifc.imemload, exp_data);
    chk("hit_iren", 32'(ifc.iREN), 32'd0);
  endtask

  task automatic flush_then_request(input logic [31:0] addr);
    @(negedge CLK);
    ifc.iflush  = 1'b1;
    ifc.imemREN = 1'b0;
    @(negedge CLK);
    ifc.iflush   = 1'b0;
    ifc.imemREN  = 1'b1;
    ifc.imemaddr = addr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    cyc_tab[0] = '{1'b0, 1'b0, 32'h0,  32'h0};
    cyc_tab[1] = '{1'b0, 1'b1, 32'h40, 32'h0};
    cyc_tab[2] = '{1'b0, 1'b1, 32'h40, 32'h0};
    cyc_tab[3] = '{1'b0, 1'b1, 32'h40, 32'h0};
    cyc_tab[4] = '{1'b0, 1'b1, 32'h44, 32'h0};
    cyc_tab[5] = '{1'b0, 1'b1, 32'h44, 32'h0};
    cyc_tab[6] = '{1'b0, 1'b1, 32'h44, 32'h0};
    cyc_tab[7] = '{1'b1, 1'b0, 32'h0,  32'h40};

    fetch_tab[0] = '{32'h44, 1'b0, 32'h44};
    fetch_tab[1] = '{32'h80, 1'b1, 32'h80};
    fetch_tab[2] = '{32'h40, 1'b0, 32'h40};
    fetch_tab[3] = '{32'hC0, 1'b1, 32'hC0};  // evicts tag 2 (LRU)
    fetch_tab[4] = '{32'h40, 1'b0, 32'h40};
    fetch_tab[5] = '{32'h80, 1'b1, 32'h80};
    fetch_tab[6] = '{32'h08, 1'b1, 32'h08};
    fetch_tab[7] = '{32'h0C, 1'b0, 32'h0C};

    ifc.imemREN  = 1'b1;
    ifc.imemaddr = 32'h40;
    ifc.iflush   = 1'b0;

    // Reset values with a request already pending.
    #3;
    chk("rst_ihit", 32'(ifc.ihit), 32'd0);
    chk("rst_imemload", ifc.imemload, 32'h0);
    chk("rst_iren", 32'(ifc.iREN), 32'd0);
    chk("rst_iaddr", ifc.iaddr, 32'h0);
    ifc.imemREN = 1'b0;

    // First miss at 0x40, cycle by cycle.
    @(negedge CLK);
    nRST         = 1'b1;
    ifc.imemREN  = 1'b1;
    ifc.imemaddr = 32'h40;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("c%0d_ihit", k), 32'(ifc.ihit), 32'(cyc_tab[k].hit));
      chk($sformatf("c%0d_iren", k), 32'(ifc.iREN), 32'(cyc_tab[k].ren));
      chk($sformatf("c%0d_iaddr", k), ifc.iaddr, cyc_tab[k].iaddr);
      chk($sformatf("c%0d_load", k), ifc.imemload, cyc_tab[k].load);
      if (k < 7) @(negedge CLK);
    end

    // Hits, misses and LRU eviction in set 0, then another set.
    for (int i = 0; i < 8; i++) begin
      fetch(fetch_tab[i].addr, fetch_tab[i].miss, fetch_tab[i].data);
    end

    // One-cycle flush while 0x40 would otherwise hit, then a full refill.
    @(negedge CLK);
    ifc.imemREN  = 1'b1;
    ifc.imemaddr = 32'h40;
    ifc.iflush   = 1'b1;
    #1;
    chk("flush_ihit", 32'(ifc.ihit), 32'd0);
    @(posedge CLK);
    #1;
    ifc.iflush  = 1'b0;
    ifc.imemREN = 1'b0;
    fetch(32'h40, 1'b1, 32'h40);

    // Flush while 0x44 is still waiting on memory.
    flush_then_request(32'h40);
    n = 0;
    while (ifc.iaddr !== 32'h44 && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("midfill_iaddr", ifc.iaddr, 32'h44);
    chk("midfill_iwait", 32'(ifc.iwait), 32'd1);
    ifc.iflush  = 1'b1;
    ifc.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    chk("midfill_iren", 32'(ifc.iREN), 32'd0);
    ifc.iflush = 1'b0;
    fetch(32'h40, 1'b1, 32'h40);

    // Flush on the very edge that accepts the last word: line must stay invalid.
    flush_then_request(32'h40);
    n = 0;
    while (!(ifc.iaddr === 32'h44 && ifc.iwait === 1'b0) && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("lastword_iaddr", ifc.iaddr, 32'h44);
    ifc.iflush  = 1'b1;
    ifc.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    ifc.iflush = 1'b0;
    fetch(32'h40, 1'b1, 32'h40);

    // Asynchronous reset in the middle of a fill.
    flush_then_request(32'h40);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("arst_pre_iren", 32'(ifc.iREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_iren", 32'(ifc.iREN), 32'd0);
    chk("arst_ihit", 32'(ifc.ihit), 32'd0);
    chk("arst_iaddr", ifc.iaddr, 32'h0);
    @(negedge CLK);
    nRST        = 1'b1;
    ifc.imemREN = 1'b0;
    fetch(32'h40, 1'b1, 32'h40);
    fetch(32'h44, 1'b0, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache, the successor to the fixed direct-mapped icache inside the caches wrapper. It sits between the datapath fetch port and the memory-side instruction channel. It returns hits combinationally and fills whole multi-word blocks on a miss through a fill state machine. Sets, ways and block size are configurable; replacement is true LRU; a flush input invalidates the whole cache.

## Interface
- SETS, 8, number of sets; power of 2, ≥2
- WAYS, 2, associativity; one of 1, 2, 4
- BLOCK_WORDS, 2, 32-bit words per block; power of 2, ≥1
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- iflush  in  1  invalidate all lines
- ihit  out  1  fetch satisfied this cycle
- imemload  out  32  fetched instruction; 0 when ihit=0
- iREN  out  1  memory read request
- iaddr  out  32  memory word address
- iwait  in  1  memory busy; word valid on iload when iwait=0 and iREN=1
- iload  in  32  memory read data

## Operation
- Address split: [1:0] byte, then OFF=log2(BLOCK_WORDS) word-offset bits, then IDX=log2(SETS) index bits, remaining upper bits are the tag.
- Storage per way per set: valid, tag, BLOCK_WORDS data words, LRU age of log2(WAYS) bits (none when WAYS=1).
- Hit: imemREN=1, state IDLE, iflush=0, and some valid way in the indexed set has a matching tag. The result is ihit=1 and imemload=word[offset] of that way, same cycle.
- LRU update on a hit clock edge:
  - the hit way's age becomes 0;
  - ways in that set younger than the hit way's old age increment;
  - other ways are unchanged.
- Miss: imemREN=1 with no hit in IDLE.
  - Capture the block base address (offset bits zeroed).
  - Capture the victim way: lowest-numbered invalid way, else the way with the maximum age.
  - Enter FILL.
- FILL:
  - iREN=1 and iaddr=base+4·cnt, with cnt running from 0 to BLOCK_WORDS-1.
  - On each cycle with iwait=0, write iload into victim word[cnt] and increment cnt.
  - On the last word: set the victim's valid and tag, apply the LRU update with the victim as MRU, clear cnt, go to IDLE.
  - ihit=0 throughout FILL.
- The fill completes even if imemREN drops or imemaddr changes mid-fill.
- IDLE outputs: iREN=0, iaddr=0.
- iflush=1 has priority over everything:
  - clears all valid bits and all ages at the clock edge;
  - aborts any FILL: next state IDLE, cnt=0, partial block discarded;
  - forces ihit=0 combinationally that cycle.
- Reset: all valid bits 0, ages 0, state IDLE, cnt 0. Data arrays need not be reset.
- Reset values of outputs: ihit=0, imemload=0, iREN=0, iaddr=0.

## Timing
- Hit latency: 0 cycles; ihit and imemload are combinational from imemaddr in IDLE.
- Miss penalty with a per-word memory wait of L cycles:
  - 1 cycle to detect the miss (IDLE→FILL edge);
  - BLOCK_WORDS·(L+1) cycles in FILL;
  - the hit returns in the first IDLE cycle after the fill.
- iREN rises the cycle after the miss is seen. iaddr is stable while iwait=1 and advances only on the edge after iwait=0.
- Nothing else changes on the FILL→IDLE edge. The same request then hits combinationally.
- Simultaneous iflush and last-word acceptance: the flush wins and the line stays invalid.
- Reset asserted mid-FILL: outputs go to reset values asynchronously and no line becomes valid.

## Test plan
All scenarios use SETS=8, WAYS=2, BLOCK_WORDS=2, and memory returning the word equal to its address with L=2.

1. **Reset.** nRST=0, then release and assert imemREN at 0x40. Required: ihit=0, iREN=1 the next cycle with iaddr=0x40, then 0x44. ihit=1 and imemload=0x40 in the cycle after the fill. A fetch of 0x44 then hits with data 0x44 and no iREN.
2. **Miss timing.** For the 0x40 miss, count cycles from the first imemREN to ihit. Required: 1+2·3 = 7 cycles of ihit=0; ihit first high at cycle 8.
3. **LRU eviction in set 0.**
   - Fetch 0x40 (tag 1), then 0x80 (tag 2), then 0x40 again; that last fetch hits.
   - Fetch 0xC0 (tag 3). Required: it misses and evicts tag 2.
   - Required: 0x40 then hits; 0x80 misses.
4. **Flush.** After scenario 1, pulse iflush for one cycle, then fetch 0x40. Required: ihit=0 during the flush cycle, and a full refill follows.
5. **Flush mid-fill.** Assert iflush while iaddr=0x44 is pending. Required: iREN=0 next cycle, and a later 0x40 fetch misses.
6. **Async reset mid-fill.** Drop nRST during FILL. Required: iREN=0 and ihit=0 immediately, and a later 0x40 fetch misses.
